// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared constants, encipher FSM encoding and byte/word helpers for the AES
// block datapath.
//   - AES_128_BIT_KEY / AES_256_BIT_KEY : keylen encodings
//   - AES128_ROUNDS / AES256_ROUNDS     : number of rounds (10 / 14)
//   - enc_state_e                       : encipher FSM states
//   - gm2 / gm3                         : GF(2^8) multiply by 2 / 3 (poly 0x11B)
//   - mixw                              : MixColumns on one 32-bit column
//   - shiftrows                         : ShiftRows on a 128-bit state
// State layout: word c (column c) is bits 127-32c -: 32, byte 0 of a word
// (row 0) is its MSB.
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam logic       AES_128_BIT_KEY = 1'b0;
    localparam logic       AES_256_BIT_KEY = 1'b1;

    localparam logic [3:0] AES128_ROUNDS   = 4'd10;
    localparam logic [3:0] AES256_ROUNDS   = 4'd14;

    typedef enum logic [1:0] {
        ENC_IDLE = 2'd0,
        ENC_INIT = 2'd1,
        ENC_SBOX = 2'd2,
        ENC_MAIN = 2'd3
    } enc_state_e;

    function automatic logic [7:0] gm2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] x);
        return gm2(x) ^ x;
    endfunction

    function automatic logic [31:0] mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        return {gm2(b0) ^ gm3(b1) ^ b2      ^ b3,
                b0      ^ gm2(b1) ^ gm3(b2) ^ b3,
                b0      ^ b1      ^ gm2(b2) ^ gm3(b3),
                gm3(b0) ^ b1      ^ b2      ^ gm2(b3)};
    endfunction

    // Row r of the result takes row r of column (c + r) mod 4.
    function automatic logic [127:0] shiftrows(input logic [127:0] b);
        return {b[127:120], b[87:80],   b[47:40],   b[7:0],
                b[95:88],   b[55:48],   b[15:8],    b[103:96],
                b[63:56],   b[23:16],   b[111:104], b[71:64],
                b[31:24],   b[119:112], b[79:72],   b[39:32]};
    endfunction

endpackage

// File: rtl/aes_encipher_block_mixcolumns.sv
// ---------------------------------------------------------------------------
// aes_mixcolumns
// Purely combinational MixColumns over a full 128-bit AES state.
//   data_i : 128-bit state in
//   data_o : 128-bit state out, each 32-bit column mixed independently
// ---------------------------------------------------------------------------
module aes_mixcolumns
    import aes_pkg::*;
(
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        assign data_o[32*gi +: 32] = mixw(data_i[32*gi +: 32]);
    end

endmodule

// File: rtl/aes_encipher_block.sv
// ---------------------------------------------------------------------------
// aes_encipher_block
// Iterative AES encipher: one 128-bit block per `next` request, 10 rounds
// (AES-128) or 14 rounds (AES-256). SubBytes is done one word per cycle
// through an external S-box shared with the key memory, so each round takes
// 4 SBOX cycles plus 1 MAIN cycle; total latency is 1 + 5N cycles.
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   next       : start pulse, sampled only while idle
//   keylen     : 0 = AES-128, 1 = AES-256, sampled with next
//   block      : plaintext, sampled with next (bits 127:96 are word 0)
//   round      : round index driving the key-memory read
//   round_key  : combinational key-memory output for `round`
//   sboxw      : word presented to the shared S-box
//   new_sboxw  : combinational S-box result for sboxw
//   new_block  : ciphertext (the state register)
//   ready      : 1 = idle with result valid, 0 = busy
// ---------------------------------------------------------------------------
module aes_encipher_block
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    input  logic [127:0] block,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw,
    output logic [127:0] new_block,
    output logic         ready
);

    enc_state_e        state_q, state_d;
    // Packed as [word index from LSB]; state word w lives at block_q[3 - w].
    logic [3:0][31:0]  block_q, block_d;
    logic [3:0]        round_q, round_d;
    logic [1:0]        word_q,  word_d;
    logic              keylen_q, keylen_d;

    logic [127:0]      shifted;
    logic [127:0]      mixed;
    logic [3:0]        last_round;

    assign shifted    = shiftrows(block_q);
    assign last_round = (keylen_q == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;

    aes_mixcolumns u_mixcolumns (
        .data_i (shifted),
        .data_o (mixed)
    );

    assign round     = round_q;
    assign sboxw     = block_q[2'd3 - word_q];
    assign new_block = block_q;
    assign ready     = (state_q == ENC_IDLE);

    always_comb begin
        state_d  = state_q;
        block_d  = block_q;
        round_d  = round_q;
        word_d   = word_q;
        keylen_d = keylen_q;
        case (state_q)
            ENC_IDLE: begin
                if (next) begin
                    block_d  = block;
                    keylen_d = keylen;
                    round_d  = 4'd0;
                    word_d   = 2'd0;
                    state_d  = ENC_INIT;
                end
            end
            ENC_INIT: begin
                block_d = block_q ^ round_key;
                round_d = 4'd1;
                word_d  = 2'd0;
                state_d = ENC_SBOX;
            end
            ENC_SBOX: begin
                block_d[2'd3 - word_q] = new_sboxw;
                word_d = word_q + 2'd1;
                if (word_q == 2'd3) begin
                    state_d = ENC_MAIN;
                end
            end
            ENC_MAIN: begin
                if (round_q < last_round) begin
                    block_d = mixed ^ round_key;
                    round_d = round_q + 4'd1;
                    state_d = ENC_SBOX;
                end else begin
                    // Final round skips MixColumns; round_q stays at N.
                    block_d = shifted ^ round_key;
                    state_d = ENC_IDLE;
                end
            end
            default: state_d = ENC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ENC_IDLE;
            block_q  <= '0;
            round_q  <= 4'd0;
            word_q   <= 2'd0;
            keylen_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            block_q  <= block_d;
            round_q  <= round_d;
            word_q   <= word_d;
            keylen_q <= keylen_d;
        end
    end

endmodule

// File: tb/tb_aes_encipher_block.sv
// ---------------------------------------------------------------------------
// tb_aes_encipher_block
// Stands in for the key memory and the shared S-box, drives directed FIPS-197
// vectors plus random blocks/keys, and compares against a byte-level AES
// reference model.
// ---------------------------------------------------------------------------
module tb_aes_encipher_block;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         next;
    logic         keylen;
    logic [127:0] block;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;
    logic [127:0] new_block;
    logic         ready;

    logic [7:0]   sbox_t [0:255];
    logic [127:0] rk     [0:14];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign round_key = rk[round];
    assign new_sboxw = {sbox_t[sboxw[31:24]], sbox_t[sboxw[23:16]],
                        sbox_t[sboxw[15:8]],  sbox_t[sboxw[7:0]]};

    aes_encipher_block dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .next      (next),
        .keylen    (keylen),
        .block     (block),
        .round     (round),
        .round_key (round_key),
        .sboxw     (sboxw),
        .new_sboxw (new_sboxw),
        .new_block (new_block),
        .ready     (ready)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                            ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Fills the key-memory model; AES-128 keys sit in key[255:128].
    task automatic load_keys(input logic [255:0] key, input logic kl);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk, nr;
        nk = kl ? 8 : 4;
        nr = kl ? 14 : 10;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= 14; r++) begin
            if (r <= nr) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk[r] = '0;
        end
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic kl);
        logic [7:0] s [0:15];
        logic [7:0] t [0:15];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] out;
        int nr;
        nr = kl ? 14 : 10;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk[0][127 - 8*i -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c + r] = s[4*((c + r) % 4) + r];
            if (rnd < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end else begin
                s = t;
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[rnd][127 - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = s[i];
        return out;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a request; returns #1 after the accepting edge E0.
    task automatic launch(input logic kl, input logic [127:0] pt,
                          input logic [255:0] key, input bit hold);
        @(negedge clk);
        load_keys(key, kl);
        block  = pt;
        keylen = kl;
        next   = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) next = 1'b0;
    endtask

    // Called #1 after E0; returns #1 after the edge where ready rises.
    task automatic wait_done(input string tag, input int nr, input bit chk_round,
                             input bit poke, output int lat);
        bit done;
        int exp_r;
        done = 1'b0;
        lat  = 0;
        check({tag, "_busy"}, 128'(ready), 128'(1'b0));
        if (chk_round) check({tag, "_round0"}, 128'(round), 128'(0));
        for (int k = 1; k <= 200 && !done; k++) begin
            @(posedge clk);
            #1;
            if (poke && k == 20) begin
                next  = 1'b1;
                block = '1;
            end
            if (poke && k == 21) next = 1'b0;
            if (chk_round) begin
                exp_r = (k - 1) / 5 + 1;
                if (exp_r > nr) exp_r = nr;
                check($sformatf("%s_round_k%0d", tag, k), 128'(round), 128'(exp_r));
            end
            if (ready) begin
                done = 1'b1;
                lat  = k;
            end
        end
        check({tag, "_latency"}, 128'(lat), 128'(1 + 5*nr));
    endtask

    task automatic run(input string tag, input logic kl, input logic [127:0] pt,
                       input logic [255:0] key, input logic [127:0] exp,
                       input bit chk_round, input bit poke);
        int lat;
        launch(kl, pt, key, 1'b0);
        wait_done(tag, kl ? 14 : 10, chk_round, poke, lat);
        check({tag, "_ct"}, new_block, exp);
        @(posedge clk);
        #1;
        check({tag, "_hold_ready"}, 128'(ready), 128'(1'b1));
        check({tag, "_hold_ct"}, new_block, exp);
        $display("run %s keylen=%0d pt=%h ct=%h latency=%0d", tag, kl, pt, new_block, lat);
    endtask

    // ---------------- stimulus ----------------
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] B_KEY = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] C1_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] C3_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        logic [127:0] pt;
        logic [255:0] key;
        logic [127:0] exp;
        logic         kl;
        int           lat;

        reset_n = 1'b0;
        next    = 1'b0;
        keylen  = 1'b0;
        block   = '0;
        for (int r = 0; r <= 14; r++) rk[r] = '0;
        build_sbox();

        // Reset state, while held and after release.
        repeat (3) @(negedge clk);
        check("rst_ready", 128'(ready), 128'(1'b1));
        check("rst_block", new_block, 128'h0);
        check("rst_round", 128'(round), 128'(0));
        check("rst_sboxw", 128'(sboxw), 128'(0));
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready", 128'(ready), 128'(1'b1));
        check("idle_block", new_block, 128'h0);
        $display("reset done");

        // FIPS-197 directed vectors.
        run("fipsB",  1'b0, B_PT, B_KEY,  B_CT,  1'b0, 1'b0);
        run("fipsC1", 1'b0, C_PT, C1_KEY, C1_CT, 1'b1, 1'b0);
        run("fipsC3", 1'b1, C_PT, C3_KEY, C3_CT, 1'b0, 1'b0);
        // next + block change while busy must be ignored.
        run("busyB",  1'b0, B_PT, B_KEY,  B_CT,  1'b0, 1'b1);

        // Reset mid-operation, asynchronous (no clock edge between).
        launch(1'b1, C_PT, C3_KEY, 1'b0);
        repeat (30) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_ready", 128'(ready), 128'(1'b1));
        check("midrst_block", new_block, 128'h0);
        check("midrst_round", 128'(round), 128'(0));
        check("midrst_sboxw", 128'(sboxw), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        $display("mid-operation reset applied");
        run("postrst", 1'b0, C_PT, C1_KEY, C1_CT, 1'b0, 1'b0);

        // Back-to-back with next held high.
        launch(1'b0, C_PT, C1_KEY, 1'b1);
        wait_done("b2b1", 10, 1'b0, 1'b0, lat);
        check("b2b1_ct", new_block, C1_CT);
        $display("run b2b1 ct=%h latency=%0d", new_block, lat);
        load_keys(C3_KEY, 1'b1);
        block  = C_PT;
        keylen = 1'b1;
        @(posedge clk);
        #1;
        next = 1'b0;
        wait_done("b2b2", 14, 1'b0, 1'b0, lat);
        check("b2b2_ct", new_block, C3_CT);
        $display("run b2b2 ct=%h latency=%0d", new_block, lat);

        // Random blocks and keys against the reference model.
        for (int i = 0; i < 6; i++) begin
            kl  = i[0];
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom};
            if (!kl) key[127:0] = '0;
            load_keys(key, kl);
            exp = ref_encrypt(pt, kl);
            run($sformatf("rand%0d", i), kl, pt, key, exp, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
